// File: rtl/cache_mem_responder_pkg.sv
// Shared types and sizing helpers for the cache backing-memory responder.
package cache_mem_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_BURST = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_WR_ACK   = 3'd5
  } state_e;

  // Counter width able to index n items; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_responder_array.sv
// Single-port word RAM with a registered, enable-gated read port (1-cycle read).
// Read register clears on reset; storage itself is never cleared.
module cache_mem_responder_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Line-burst memory responder: refill after READ_LATENCY, write-back ack WRITE_LATENCY after last beat.
// One request in flight; read beats hold while rready=0, write beats taken whenever wvalid.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_DEPTH      = 1024,
  parameter int READ_LATENCY   = 4,
  parameter int WRITE_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rlast,
  input  logic              rready,
  output logic              wr_done
);

  localparam int IDX_W   = cnt_w(MEM_DEPTH);
  localparam int BEAT_W  = cnt_w(WORDS_PER_LINE);
  localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int LAT_W   = cnt_w(LAT_MAX);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [IDX_W-1:0]  LINE_MASK = ~IDX_W'(WORDS_PER_LINE - 1);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [IDX_W-1:0]   base_q, base_d;
  logic               up_q, up_d;

  logic               ram_we, ram_re;
  logic [IDX_W-1:0]   ram_addr;
  logic [IDX_W-1:0]   req_idx;
  logic               unused_addr_bits;

  // Word index wraps at MEM_DEPTH, so upper address bits simply alias.
  assign req_idx          = req_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      up_q    <= up_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    base_d  = base_q;
    up_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && up_q) begin
          base_d = req_idx & LINE_MASK;
          beat_d = '0;
          if (req_write) begin
            state_d = ST_WR_DATA;
          end else begin
            state_d = ST_RD_WAIT;
            lat_d   = LAT_W'(READ_LATENCY - 1);
          end
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == '0) state_d = ST_RD_BURST;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      ST_RD_BURST: begin
        if (rready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_WR_DATA: begin
        if (wvalid) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_WR_WAIT;
            lat_d   = LAT_W'(WRITE_LATENCY - 1);
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_WR_WAIT: begin
        if (lat_q == '0) state_d = ST_WR_ACK;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      ST_WR_ACK: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // RAM is read one beat ahead so its registered output lines up with rvalid.
  always_comb begin
    req_ready = (state_q == ST_IDLE) && up_q;
    wready    = (state_q == ST_WR_DATA);
    rvalid    = (state_q == ST_RD_BURST);
    rlast     = rvalid && (beat_q == LAST_BEAT);
    wr_done   = (state_q == ST_WR_ACK);
    ram_we    = wready && wvalid;
    ram_re    = ((state_q == ST_RD_WAIT) && (lat_q == '0)) || rvalid;
    ram_addr  = base_q + IDX_W'(ram_we ? beat_q : beat_d);
  end

  cache_mem_responder_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

endmodule
